alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one valid/ready ALU among
// NREQ requesters and steers results back through an in-order tag FIFO.
module alu_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 32,
  parameter int OP_W      = 3,
  parameter int TAG_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NREQ-1:0]            req_valid_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic [NREQ*DATA_W-1:0]     req_in1_i,
  input  logic [NREQ*DATA_W-1:0]     req_in2_i,
  input  logic [NREQ*OP_W-1:0]       req_op_i,
  output logic [NREQ-1:0]            rsp_valid_o,
  input  logic [NREQ-1:0]            rsp_ready_i,
  output logic [DATA_W-1:0]          rsp_res_o,
  output logic [DATA_W-1:0]          alu_in1_o,
  output logic [DATA_W-1:0]          alu_in2_o,
  output logic [OP_W-1:0]            alu_op_o,
  output logic                       alu_in_valid_o,
  input  logic                       alu_in_ready_i,
  input  logic [DATA_W-1:0]          alu_res_i,
  input  logic                       alu_out_valid_i,
  output logic                       alu_out_ready_o,
  output logic [$clog2(TAG_DEPTH):0] inflight_o,
  output logic                       err_orphan_o
);

  localparam int IW = $clog2(NREQ);
  localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH) + 1;

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic          lock_q, lock_d;
  logic [IW-1:0] gnt_idx;
  logic          gnt_any;
  int            scan_idx;

  logic [IW-1:0] tag_mem_q [TAG_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          can_issue, push, pop, empty;
  logic [IW-1:0] head;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Grant select: held index while locked, else first valid from rr_ptr.
  // Scanning from the far end down lets the nearest valid requester win.
  always_comb begin
    gnt_idx  = lock_idx_q;
    gnt_any  = lock_q;
    scan_idx = 0;
    if (!lock_q) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        scan_idx = (int'(rr_ptr_q) + k) % NREQ;
        if (req_valid_i[scan_idx]) begin
          gnt_idx = IW'(scan_idx);
          gnt_any = 1'b1;
        end
      end
    end
  end

  // Issue side handshake and payload mux.
  always_comb begin
    can_issue      = cnt_q < CW'(TAG_DEPTH);
    alu_in_valid_o = can_issue & gnt_any;
    push           = alu_in_valid_o & alu_in_ready_i;
    req_ready_o    = push ? (NREQ'(1) << gnt_idx) : '0;
    alu_in1_o      = gnt_any ? req_in1_i[gnt_idx*DATA_W +: DATA_W] : '0;
    alu_in2_o      = gnt_any ? req_in2_i[gnt_idx*DATA_W +: DATA_W] : '0;
    alu_op_o       = gnt_any ? req_op_i[gnt_idx*OP_W +: OP_W] : '0;
  end

  // Response side: head tag steers valid/ready; empty FIFO blocks results.
  always_comb begin
    empty           = (cnt_q == '0);
    head            = tag_mem_q[rd_ptr_q];
    rsp_valid_o     = (alu_out_valid_i & !empty) ? (NREQ'(1) << head) : '0;
    alu_out_ready_o = rsp_ready_i[head] & !empty;
    pop             = alu_out_valid_i & alu_out_ready_o;
    rsp_res_o       = alu_res_i;
    inflight_o      = cnt_q;
    err_orphan_o    = err_q;
  end

  // Arbitration next state: advance past the winner on issue, lock on stall.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (push) begin
      rr_ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      lock_d   = 1'b0;
    end else if (alu_in_valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Tag storage; contents are don't-care while the slot is free.
  always_ff @(posedge clk_i) begin
    if (push) tag_mem_q[wr_ptr_q] <= gnt_idx;
  end

  // Tag FIFO pointers/occupancy and the sticky orphan flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      if (alu_out_valid_i && empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed + random stimulus against a queue-based model of
// the arbiter; the bench also plays an in-order pipelined ALU.
module tb_alu_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int OW = 3;
  localparam int TD = 4;
  localparam int CW = $clog2(TD) + 1;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*DW-1:0] req_in1, req_in2;
  logic [N*OW-1:0] req_op;
  logic [DW-1:0]   rsp_res, alu_in1, alu_in2, alu_res;
  logic [OW-1:0]   alu_op;
  logic            alu_in_valid, alu_in_ready, alu_out_valid, alu_out_ready, err_orphan;
  logic [CW-1:0]   inflight;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(N), .DATA_W(DW), .OP_W(OW), .TAG_DEPTH(TD)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_in1_i(req_in1), .req_in2_i(req_in2), .req_op_i(req_op),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_res_o(rsp_res),
    .alu_in1_o(alu_in1), .alu_in2_o(alu_in2), .alu_op_o(alu_op),
    .alu_in_valid_o(alu_in_valid), .alu_in_ready_i(alu_in_ready),
    .alu_res_i(alu_res), .alu_out_valid_i(alu_out_valid), .alu_out_ready_o(alu_out_ready),
    .inflight_o(inflight), .err_orphan_o(err_orphan)
  );

  // reference model state
  int            m_rr, m_lidx;
  bit            m_lock, m_orph;
  int            m_tags[$];
  logic [DW-1:0] m_res [N][$];

  // ALU model state
  typedef struct { logic [DW-1:0] res; int due; } pe_t;
  pe_t pipe[$];
  int  cyc, lat;
  bit  ov_en, force_orph;

  int            checks, errors;
  logic [N-1:0]  last_acc;
  logic [2*DW+OW-1:0] p2;
  int            order[5];

  function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op, input logic [DW-1:0] a, b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_lidx = 0; m_lock = 0; m_orph = 0;
    m_tags.delete();
    foreach (m_res[i]) m_res[i].delete();
    pipe.delete();
  endtask

  task automatic drive_alu();
    if (force_orph) begin
      alu_out_valid = 1'b1; alu_res = 32'hdead_beef;
    end else if (ov_en && pipe.size() > 0 && pipe[0].due <= cyc) begin
      alu_out_valid = 1'b1; alu_res = pipe[0].res;
    end else begin
      alu_out_valid = 1'b0; alu_res = $urandom;
    end
  endtask

  task automatic settle();
    drive_alu();
    #1;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op);
    req_in1[i*DW +: DW] = a;
    req_in2[i*DW +: DW] = b;
    req_op[i*OW +: OW]  = op;
  endtask

  // One clock: check DUT against the model, then advance model and ALU.
  task automatic step();
    int g, gi, head;
    bit can, ivld, iss, pop, orph_ev;
    logic [N-1:0] e_rdy, e_rv;
    bit e_ordy;
    logic [2*DW+OW-1:0] e_pl;
    logic [DW-1:0] e_res;
    settle();
    can = m_tags.size() < TD;
    g = -1;
    if (m_lock) g = m_lidx;
    else for (int k = 0; k < N; k++) if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
    gi    = (g >= 0) ? g : 0;
    ivld  = can && (g >= 0);
    iss   = ivld && alu_in_ready;
    e_rdy = iss ? (N'(1) << g) : '0;
    e_pl  = (g >= 0) ? {req_in1[gi*DW +: DW], req_in2[gi*DW +: DW], req_op[gi*OW +: OW]} : '0;
    e_res = alu_f(req_op[gi*OW +: OW], req_in1[gi*DW +: DW], req_in2[gi*DW +: DW]);
    head  = (m_tags.size() > 0) ? m_tags[0] : 0;
    e_rv  = (alu_out_valid && m_tags.size() > 0) ? (N'(1) << head) : '0;
    e_ordy = (m_tags.size() > 0) && rsp_ready[head];
    pop   = alu_out_valid && e_ordy;
    orph_ev = alu_out_valid && (m_tags.size() == 0);
    chk("alu_in_valid", alu_in_valid, ivld);
    chk("req_ready", req_ready, e_rdy);
    chk("alu_payload", {alu_in1, alu_in2, alu_op}, e_pl);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("alu_out_ready", alu_out_ready, e_ordy);
    chk("inflight", inflight, m_tags.size());
    chk("err_orphan", err_orphan, m_orph);
    if (pop) chk("rsp_res", rsp_res, m_res[head].pop_front());
    last_acc = req_ready;
    if (alu_out_valid && alu_out_ready && !force_orph && pipe.size() > 0) void'(pipe.pop_front());
    if (alu_in_valid && alu_in_ready) pipe.push_back('{alu_f(alu_op, alu_in1, alu_in2), cyc + lat});
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (pop) void'(m_tags.pop_front());
      if (iss) begin
        m_tags.push_back(g);
        m_res[g].push_back(e_res);
        m_rr = (g + 1) % N;
        m_lock = 0;
      end else if (ivld) begin
        m_lock = 1; m_lidx = g;
      end
      if (orph_ev) m_orph = 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int k;
    req_valid = '0; rsp_ready = '1; ov_en = 1; alu_in_ready = 1;
    k = 0;
    while (m_tags.size() > 0 && k < 40) begin step(); k++; end
    settle();
    chk("drain", inflight, 0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; lat = 2; ov_en = 1; force_orph = 0;
    rst = 1; req_valid = 4'b1111; alu_in_ready = 1; rsp_ready = '1;
    for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom, OW'($urandom));
    model_reset();
    drive_alu();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    // reset: first grant goes to requester 0
    settle();
    chk("rst_inflight", inflight, 0);
    chk("rst_grant", req_ready, 4'b0001);
    // round-robin with everyone requesting
    order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("rr_all", req_ready, N'(1) << order[k]);
      step();
    end
    req_valid = 4'b0010; step();             // rr_ptr now 2
    req_valid = 4'b1010;
    order = '{3, 1, 3, 0, 0};
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("rr_1010", req_ready, N'(1) << order[k]);
      step();
    end
    // stall lock on requester 2
    req_valid = 4'b0100; alu_in_ready = 0;
    p2 = {req_in1[2*DW +: DW], req_in2[2*DW +: DW], req_op[2*OW +: OW]};
    step();
    req_valid = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("stall_payload", {alu_in1, alu_in2, alu_op}, p2);
      step();
    end
    alu_in_ready = 1;
    settle();
    chk("stall_release", req_ready, 4'b0100);
    step();
    req_valid = 4'b0001;
    settle();
    chk("stall_next", req_ready, 4'b0001);
    step();
    drain();
    // routing of two ADDs through a latency-2 ALU
    set_req(1, 5, 3, 0);
    set_req(3, 7, 1, 0);
    rsp_ready = 4'b1101;
    req_valid = 4'b0010; step();
    req_valid = 4'b1000; step();
    req_valid = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("route_hold_rv", rsp_valid, 4'b0010);
      chk("route_hold_ordy", alu_out_ready, 0);
      step();
    end
    rsp_ready = '1;
    settle();
    chk("route_r1_rv", rsp_valid, 4'b0010);
    chk("route_r1_res", rsp_res, 8);
    step();
    settle();
    chk("route_r3_rv", rsp_valid, 4'b1000);
    chk("route_r3_res", rsp_res, 8);
    step();
    drain();
    // fill the tag FIFO
    ov_en = 0; req_valid = 4'b1111;
    repeat (4) step();
    settle();
    chk("full_inflight", inflight, 4);
    chk("full_in_valid", alu_in_valid, 0);
    step();
    ov_en = 1;
    settle();
    chk("full_pop_in_valid", alu_in_valid, 0);
    chk("full_pop_ordy", alu_out_ready, 1);
    step();
    settle();
    chk("full_after_inflight", inflight, 3);
    chk("full_after_in_valid", alu_in_valid, 1);
    step();
    drain();
    // reset with operations in flight
    ov_en = 0; req_valid = 4'b1111;
    repeat (2) step();
    rst = 1; step();
    rst = 0; req_valid = '0; ov_en = 1;
    settle();
    chk("midrst_inflight", inflight, 0);
    step();
    // random traffic
    last_acc = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !last_acc[i])) begin
          if ($urandom_range(0, 2) == 0) begin
            req_valid[i] = 1'b1;
            set_req(i, $urandom, $urandom, OW'($urandom));
          end else req_valid[i] = 1'b0;
        end
      end
      alu_in_ready = ($urandom_range(0, 3) != 0);
      rsp_ready    = N'($urandom);
      lat          = $urandom_range(1, 3);
      ov_en        = ($urandom_range(0, 4) != 0);
      step();
    end
    lat = 2;
    drain();
    // orphan result
    force_orph = 1;
    settle();
    chk("orph_ordy", alu_out_ready, 0);
    chk("orph_rv", rsp_valid, 0);
    chk("orph_before", err_orphan, 0);
    step();
    force_orph = 0;
    settle();
    chk("orph_sticky", err_orphan, 1);
    repeat (2) step();
    rst = 1; step();
    rst = 0;
    settle();
    chk("orph_cleared", err_orphan, 0);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
